// File: rtl/unmatch_fifo_fwft.sv
// First-word-fall-through literal FIFO between the LZ4 match finder
// and the sequence packer; head word on dout whenever empty=0.
//
// Parameters:
//   DW         data width
//   AW         address width, DEPTH = 2**AW words total capacity
//   AF_THRESH  almost_full when data_count >= AF_THRESH
//   AE_THRESH  almost_empty when data_count <= AE_THRESH
// Ports:
//   clk, rstN (async active-low), clr (sync flush)
//   din/wr_en       write side, accepted iff wr_en & ~full
//   rd_en           pop of the current dout, accepted iff ~empty
//   dout            registered head word, held while empty
//   valid           rd_en & ~empty (pop accepted this cycle)
//   full/empty/almost_full/almost_empty/data_count  registered
//   overflow/underflow  sticky error flags, cleared by rstN/clr
// Optional build macro UNMATCH_FIFO_WATERMARK_EN adds max_count,
// the highest data_count seen since reset or clr.

module unmatch_fifo_fwft #(
   parameter int DW        = 32,
   parameter int AW        = 12,
   parameter int AF_THRESH = 4032,
   parameter int AE_THRESH = 64
) (
   input  logic          clk,
   input  logic          rstN,
   input  logic          clr,
   input  logic [DW-1:0] din,
   input  logic          wr_en,
   input  logic          rd_en,
   output logic [DW-1:0] dout,
   output logic          valid,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic [AW:0]   data_count,
   output logic          overflow,
   output logic          underflow
`ifdef UNMATCH_FIFO_WATERMARK_EN
   ,
   output logic [AW:0]   max_count
`endif
);

   localparam int          DEPTH   = 1 << AW;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   if (AF_THRESH > DEPTH || AE_THRESH >= AF_THRESH) begin : g_param_err
      $error("unmatch_fifo_fwft: need AE_THRESH < AF_THRESH <= DEPTH");
   end

   logic [DW-1:0] mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW:0]   remain;
   logic [DW-1:0] dout_q, dout_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          af_q, af_d;
   logic          ae_q, ae_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          wr_acc;
   logic          rd_acc;

   // Accept decisions use the registered flags only; clr wins.
   always_comb begin
      wr_acc = wr_en & ~full_q & ~clr;
      rd_acc = rd_en & ~empty_q & ~clr;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_acc, rd_acc})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   // Words left from before this edge once the pop is taken.
   // When none remain, the new head is the word written now,
   // so it bypasses the RAM straight into the output register.
   always_comb begin
      remain = cnt_q - (AW+1)'(rd_acc);
      dout_d = dout_q;
      if (clr) begin
         dout_d = '0;
      end else if (cnt_d != '0) begin
         if (remain == '0) dout_d = din;
         else              dout_d = mem_q[rd_ptr_d];
      end
   end

   always_comb begin
      full_d  = (cnt_d == DEPTH_C);
      empty_d = (cnt_d == '0);
      af_d    = (cnt_d >= AF_C);
      ae_d    = (cnt_d <= AE_C);
      ovf_d   = ovf_q | (wr_en & full_q);
      udf_d   = udf_q | (rd_en & empty_q);
      if (clr) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

`ifdef UNMATCH_FIFO_WATERMARK_EN
   logic [AW:0] max_q, max_d;

   always_comb begin
      max_d = max_q;
      if (cnt_d > max_q) max_d = cnt_d;
      if (clr)           max_d = '0;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) max_q <= '0;
      else       max_q <= max_d;
   end

   assign max_count = max_q;
`endif

   assign dout         = dout_q;
   assign valid        = rd_en & ~empty_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign data_count   = cnt_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_unmatch_fifo_fwft.sv
// Bench for unmatch_fifo_fwft: vector table, hand corner
// sequences and random traffic against a queue model.

module tb_unmatch_fifo_fwft;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int DEPTH = 16;
   localparam int AFT = 14;
   localparam int AET = 2;

   logic          clk = 1'b0;
   logic          rstN;
   logic          clr;
   logic [DW-1:0] din;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] dout;
   logic          valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   data_count;
   logic          overflow;
   logic          underflow;
`ifdef UNMATCH_FIFO_WATERMARK_EN
   logic [AW:0]   max_count;
`endif

   always #5 clk = ~clk;

   unmatch_fifo_fwft #(
      .DW(DW), .AW(AW), .AF_THRESH(AFT), .AE_THRESH(AET)
   ) dut (
      .clk(clk),
      .rstN(rstN),
      .clr(clr),
      .din(din),
      .wr_en(wr_en),
      .rd_en(rd_en),
      .dout(dout),
      .valid(valid),
      .full(full),
      .empty(empty),
      .almost_full(almost_full),
      .almost_empty(almost_empty),
      .data_count(data_count),
      .overflow(overflow),
`ifdef UNMATCH_FIFO_WATERMARK_EN
      .max_count(max_count),
`endif
      .underflow(underflow)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h",
                  nm, act, exp);
      end
   endtask

   // Reference model: a plain queue of the stored words.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_dout;
   logic          m_ovf, m_udf;
   int            m_max;

   task automatic m_reset();
      mq.delete();
      m_dout = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_max = 0;
   endtask

   task automatic m_step(input logic c, w, r,
                         input logic [DW-1:0] d);
      int n;
      bit was_full, was_empty;
      if (c) begin
         m_reset();
         return;
      end
      n = mq.size();
      was_full = (n == DEPTH);
      was_empty = (n == 0);
      if (w && was_full) m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
      if (r && !was_empty) void'(mq.pop_front());
      if (w && !was_full) mq.push_back(d);
      if (mq.size() > 0) m_dout = mq[0];
      if (mq.size() > m_max) m_max = mq.size();
   endtask

   task automatic m_check(input string p);
      int n;
      n = mq.size();
      chk({p, ".count"}, 64'(data_count), 64'(n));
      chk({p, ".empty"}, 64'(empty), 64'(n == 0));
      chk({p, ".full"}, 64'(full), 64'(n == DEPTH));
      chk({p, ".af"}, 64'(almost_full), 64'(n >= AFT));
      chk({p, ".ae"}, 64'(almost_empty), 64'(n <= AET));
      chk({p, ".ovf"}, 64'(overflow), 64'(m_ovf));
      chk({p, ".udf"}, 64'(underflow), 64'(m_udf));
      chk({p, ".dout"}, 64'(dout), 64'(m_dout));
`ifdef UNMATCH_FIFO_WATERMARK_EN
      chk({p, ".max"}, 64'(max_count), 64'(m_max));
`endif
   endtask

   // One clock: drive, check valid, clock, check all outputs.
   task automatic cyc(input logic c, w, r,
                      input logic [DW-1:0] d);
      clr = c;
      wr_en = w;
      rd_en = r;
      din = d;
      #1;
      chk("valid", 64'(valid), 64'(r && mq.size() != 0));
      m_step(c, w, r, d);
      @(posedge clk);
      #1;
      m_check("model");
   endtask

   typedef struct {
      logic          c, w, r;
      logic [DW-1:0] d;
      logic [DW-1:0] e_dout;
      logic [AW:0]   e_cnt;
      logic          e_empty;
      logic          e_udf;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 5'd1, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h11, 8'hA5, 5'd2, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 5'd1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 8'h22, 8'h22, 5'd1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h22, 5'd0, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h22, 5'd0, 1'b1, 1'b1};
      tbl[6] = '{1'b0, 1'b1, 1'b1, 8'h3C, 8'h3C, 5'd1, 1'b0, 1'b1};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 8'h55, 8'h00, 5'd0, 1'b1, 1'b0};

      rstN = 1'b0;
      clr = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      din = '0;
      m_reset();
      #12;
      m_check("reset");
      rstN = 1'b1;
      @(posedge clk);
      #1;

      // Vector table, starting from reset.
      for (int i = 0; i < 8; i++) begin
         cyc(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].d);
         chk($sformatf("tbl%0d.dout", i),
             64'(dout), 64'(tbl[i].e_dout));
         chk($sformatf("tbl%0d.cnt", i),
             64'(data_count), 64'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d.empty", i),
             64'(empty), 64'(tbl[i].e_empty));
         chk($sformatf("tbl%0d.udf", i),
             64'(underflow), 64'(tbl[i].e_udf));
      end
      chk("t1.ae_after_clr", 64'(almost_empty), 64'd1);

      // Fill to full, overflow, drain in order.
      for (int k = 0; k < 16; k++) begin
         cyc(1'b0, 1'b1, 1'b0, DW'(k));
         if (k == 12) chk("t2.af13", 64'(almost_full), 64'd0);
         if (k == 13) chk("t2.af14", 64'(almost_full), 64'd1);
         if (k == 14) chk("t2.full15", 64'(full), 64'd0);
      end
      chk("t2.full16", 64'(full), 64'd1);
      cyc(1'b0, 1'b1, 1'b0, 8'h99);
      chk("t2.ovf", 64'(overflow), 64'd1);
      chk("t2.cnt", 64'(data_count), 64'd16);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("t2.pop%0d", k), 64'(dout), 64'(k));
         cyc(1'b0, 1'b0, 1'b1, 8'h00);
      end
      chk("t2.empty", 64'(empty), 64'd1);
      chk("t2.hold", 64'(dout), 64'd15);

      // Streaming at occupancy 1 across many pointer wraps.
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 1'b0, 8'h80);
      for (int i = 1; i <= 100; i++) begin
         cyc(1'b0, 1'b1, 1'b1, DW'(i + 8'h80));
         chk($sformatf("t3.d%0d", i),
             64'(dout), 64'(DW'(i + 8'h80)));
         chk($sformatf("t3.c%0d", i), 64'(data_count), 64'd1);
      end

      // Write+read while full: read wins, write dropped.
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 16; k++)
         cyc(1'b0, 1'b1, 1'b0, DW'(8'h40 + k));
      cyc(1'b0, 1'b1, 1'b1, 8'h77);
      chk("t4.ovf", 64'(overflow), 64'd1);
      chk("t4.cnt", 64'(data_count), 64'd15);
      chk("t4.head", 64'(dout), 64'h41);

      // clr with write, then async reset mid-stream.
      for (int k = 0; k < 10; k++)
         cyc(1'b0, 1'b1, 1'b1, DW'(k + 3));
      cyc(1'b1, 1'b1, 1'b0, 8'hEE);
      chk("t5.cnt", 64'(data_count), 64'd0);
      chk("t5.empty", 64'(empty), 64'd1);
      chk("t5.ovf", 64'(overflow), 64'd0);
      for (int k = 0; k < 6; k++)
         cyc(1'b0, 1'b1, 1'b0, DW'(k + 9));
      #3;
      rstN = 1'b0;
      #1;
      m_reset();
      m_check("areset");
      chk("t5.rst_dout", 64'(dout), 64'd0);
      clr = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      #2;
      rstN = 1'b1;
      @(posedge clk);
      #1;

`ifdef UNMATCH_FIFO_WATERMARK_EN
      for (int k = 0; k < 12; k++)
         cyc(1'b0, 1'b1, 1'b0, DW'(k));
      for (int k = 0; k < 12; k++)
         cyc(1'b0, 1'b0, 1'b1, 8'h00);
      for (int k = 0; k < 5; k++)
         cyc(1'b0, 1'b1, 1'b0, DW'(k));
      chk("t6.max", 64'(max_count), 64'd12);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      chk("t6.clr", 64'(max_count), 64'd0);
`endif

      // Random traffic with phases biased to fill or drain.
      for (int i = 0; i < 1500; i++) begin
         int wp, rp;
         logic c, w, r;
         wp = ((i / 100) % 2 == 0) ? 75 : 35;
         rp = 110 - wp;
         c = ($urandom_range(0, 199) == 0);
         w = ($urandom_range(0, 99) < wp);
         r = ($urandom_range(0, 99) < rp);
         cyc(c, w, r, DW'($urandom_range(0, 255)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
